ysyx_22040895_imem: RTL and testbench



---
 rtl/ysyx_22040895_imem_pkg.sv | 19 +
 rtl/ysyx_22040895_imem_sram.sv | 30 +++
 rtl/ysyx_22040895_imem.sv | 135 +++++++++++++
 tb/tb_ysyx_22040895_imem.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory responder.
// Optional misalignment check: YSYX_22040895_IMEM_ALIGN_CHK_EN.
package ysyx_22040895_imem_pkg;

    localparam int          IMEM_ADDR_W     = 32;
    localparam int          IMEM_DATA_W     = 32;
    localparam int          IMEM_DEPTH_LOG2 = 12;
    localparam int          IMEM_LATENCY    = 2;
    localparam int          IMEM_CNT_W      = 4;
    localparam logic [31:0] IMEM_BASE_ADDR  = 32'h8000_0000;
    localparam logic [31:0] IMEM_ZERO_INST  = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } imem_state_e;

endpackage

// File: rtl/ysyx_22040895_imem_sram.sv
// 1R1W word array with registered read-before-write and no reset.
// Read data holds its value while re_i is low.
module ysyx_22040895_imem_sram #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_22040895_imem.sv
// Fixed-latency instruction-memory responder, single outstanding request.
// Define YSYX_22040895_IMEM_ALIGN_CHK_EN to flag misaligned addresses.
module ysyx_22040895_imem
    import ysyx_22040895_imem_pkg::*;
#(
    parameter int                ADDR_W     = IMEM_ADDR_W,
    parameter int                DATA_W     = IMEM_DATA_W,
    parameter int                DEPTH_LOG2 = IMEM_DEPTH_LOG2,
    parameter int                LATENCY    = IMEM_LATENCY,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(IMEM_BASE_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_W-1:0]     req_addr_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_W-1:0]     resp_inst_o,
    output logic                  resp_err_o,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i
);

    imem_state_e             state_q, state_d;
    logic [IMEM_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    hit_q, hit_d;
    logic                    err_q, err_d;
    logic                    rd_en;
    logic [ADDR_W-1:0]       off;
    logic                    oor;
    logic                    mis;
    logic                    err_raw;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [DATA_W-1:0]       rdata;
    logic                    unused_lo;

    assign off       = addr_q - BASE_ADDR;
    assign idx       = off[DEPTH_LOG2+1:2];
    assign unused_lo = ^off[1:0];

    if (DEPTH_LOG2 + 2 < ADDR_W) begin : g_rng
        assign oor = |off[ADDR_W-1:DEPTH_LOG2+2];
    end else begin : g_full
        assign oor = 1'b0;
    end

`ifdef YSYX_22040895_IMEM_ALIGN_CHK_EN
    assign mis = |addr_q[1:0];
`else
    assign mis = 1'b0;
`endif

    assign err_raw = oor | mis;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        hit_d   = hit_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_d  = req_addr_i;
                        cnt_d   = IMEM_CNT_W'(LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // the array read lands on the same edge that enters RESP
                    if (cnt_q == '0) begin
                        rd_en   = ~err_raw;
                        hit_d   = ~err_raw;
                        err_d   = err_raw;
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
        end
    end

    ysyx_22040895_imem_sram #(
        .DW (DATA_W),
        .AW (DEPTH_LOG2)
    ) u_sram (
        .clk     (clk),
        .re_i    (rd_en),
        .raddr_i (idx),
        .we_i    (wr_en_i),
        .waddr_i (wr_addr_i),
        .wdata_i (wr_data_i),
        .rdata_o (rdata)
    );

    assign req_ready_o  = (state_q == S_IDLE) & ~flush_i;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_err_o   = err_q;
    assign resp_inst_o  = hit_q ? rdata : DATA_W'(IMEM_ZERO_INST);

endmodule

// File: tb/tb_ysyx_22040895_imem.sv
// Directed bench for the instruction-memory responder.
// Honours YSYX_22040895_IMEM_ALIGN_CHK_EN for the misaligned case.
module tb_ysyx_22040895_imem;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        flush;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    int n_cmp;
    int n_err;

    ysyx_22040895_imem #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DEPTH_LOG2 (12),
        .LATENCY    (LAT),
        .BASE_ADDR  (32'h8000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_inst_o  (resp_inst),
        .resp_err_o   (resp_err),
        .flush_i      (flush),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] a,
                         input logic [31:0] ei, input logic ee);
        req_valid  = 1'b1;
        req_addr   = a;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check({tag, "_rdy_busy"}, 32'(req_ready), 32'd0);
        check({tag, "_vld_early"}, 32'(resp_valid), 32'd0);
        for (int i = 1; i < LAT; i++) begin
            tick();
            check({tag, "_vld_wait"}, 32'(resp_valid), 32'd0);
        end
        tick();
        check({tag, "_vld"}, 32'(resp_valid), 32'd1);
        check({tag, "_inst"}, resp_inst, ei);
        check({tag, "_err"}, 32'(resp_err), 32'(ee));
        tick();
        check({tag, "_vld_done"}, 32'(resp_valid), 32'd0);
        check({tag, "_rdy_done"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        flush      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        #1;
        check("rst_rdy", 32'(req_ready), 32'd1);
        check("rst_vld", 32'(resp_valid), 32'd0);
        check("rst_inst", resp_inst, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        preload(12'd0, 32'h0000_0413);
        preload(12'd1, 32'h1234_5678);
        preload(12'd2, 32'h1111_1111);
        preload(12'd4095, 32'hDEAD_BEEF);

        fetch("w0", 32'h8000_0000, 32'h0000_0413, 1'b0);
        fetch("w1", 32'h8000_0004, 32'h1234_5678, 1'b0);
        fetch("last", 32'h8000_3FFC, 32'hDEAD_BEEF, 1'b0);
        fetch("oor", 32'h8000_4000, 32'h0, 1'b1);
        fetch("below", 32'h7FFF_FFFC, 32'h0, 1'b1);
`ifdef YSYX_22040895_IMEM_ALIGN_CHK_EN
        fetch("misal", 32'h8000_0002, 32'h0, 1'b1);
`else
        fetch("misal", 32'h8000_0002, 32'h0000_0413, 1'b0);
`endif

        // backpressure: response must hold for ten cycles
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h8000_0004;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_vld", 32'(resp_valid), 32'd1);
            check("bp_inst", resp_inst, 32'h1234_5678);
            check("bp_rdy", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("bp_rel_vld", 32'(resp_valid), 32'd0);
        check("bp_rel_rdy", 32'(req_ready), 32'd1);

        // flush while waiting drops the request
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000;
        tick();
        flush = 1'b1;
        #1;
        check("fl_rdy_low", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b0;
            check("fl_novld", 32'(resp_valid), 32'd0);
            if (i == 0) begin
                req_valid = 1'b1;
                req_addr  = 32'h8000_0004;
                #1;
                check("fl_rdy_after", 32'(req_ready), 32'd1);
                tick();
                req_valid = 1'b0;
                break;
            end
        end
        for (int i = 1; i < LAT; i++) begin
            check("fl_new_wait", 32'(resp_valid), 32'd0);
            tick();
        end
        tick();
        check("fl_new_vld", 32'(resp_valid), 32'd1);
        check("fl_new_inst", resp_inst, 32'h1234_5678);
        tick();
        check("fl_new_done", 32'(resp_valid), 32'd0);

        // flush together with a request in IDLE: not accepted
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000;
        #1;
        check("fli_rdy", 32'(req_ready), 32'd0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("fli_idle_rdy", 32'(req_ready), 32'd1);
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            check("fli_novld", 32'(resp_valid), 32'd0);
        end

        // read and write of the same word on one edge returns old data
        req_valid = 1'b1;
        req_addr  = 32'h8000_0008;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        wr_en   = 1'b1;
        wr_addr = 12'd2;
        wr_data = 32'h2222_2222;
        tick();
        wr_en = 1'b0;
        check("rbw_vld", 32'(resp_valid), 32'd1);
        check("rbw_old", resp_inst, 32'h1111_1111);
        tick();
        fetch("rbw_new", 32'h8000_0008, 32'h2222_2222, 1'b0);

        // reset while responding
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h8000_0004;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        tick();
        check("mrst_pre_vld", 32'(resp_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("mrst_vld", 32'(resp_valid), 32'd0);
        check("mrst_inst", resp_inst, 32'd0);
        check("mrst_err", 32'(resp_err), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("mrst_rdy", 32'(req_ready), 32'd1);
        check("mrst_vld2", 32'(resp_valid), 32'd0);
        fetch("post_rst", 32'h8000_0000, 32'h0000_0413, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
